// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential nibble-serial prefix adder.
package seq_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Number of nibble steps needed to cover a given operand width.
  function automatic int unsigned nibble_count(input int unsigned width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_prefix_slice.sv
// Combinational 4-bit adder slice with a two-level parallel-prefix carry tree.
// c3 exposes the carry into bit 3 so the top can derive signed overflow.
module nibble_prefix_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g10, p10, g32, p32;
  logic       g20, p20, g30, p30;
  logic [3:0] c;

  // Bit generate/propagate, prefix combine, then carries and sum.
  always_comb begin
    g = x & y;
    p = x ^ y;

    // Level 1: pairwise groups.
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];

    // Level 2: extend groups down to bit 0.
    g20 = g[2] | (p[2] & g10);
    p20 = p[2] & p10;
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;

    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g10 | (p10 & cin);
    c[3] = g20 | (p20 & cin);

    s    = p ^ c;
    cout = g30 | (p30 & cin);
    c3   = c[3];
  end

endmodule

// File: rtl/seq_prefix_adder32.sv
// Multi-cycle adder: accepts an operand pair, adds one nibble per cycle LSB first
// through a registered carry, then presents sum/cout on a valid/ready handshake.
// Optional signed-overflow output enabled by defining SEQ_ADDER_OVERFLOW_EN.
module seq_prefix_adder32
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SEQ_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned Nibbles = nibble_count(WIDTH);
  localparam int unsigned CntW    = (Nibbles > 1) ? $clog2(Nibbles) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Nibbles - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_width_check
    $error("seq_prefix_adder32: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic [3:0]       slice_s;
  logic             slice_cout;
  logic             slice_c3;

`ifdef SEQ_ADDER_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`else
  logic             unused_c3;
  assign unused_c3 = slice_c3;
`endif

  nibble_prefix_slice u_slice (
    .x    (a_q[cnt_q * NIBBLE_W +: NIBBLE_W]),
    .y    (b_q[cnt_q * NIBBLE_W +: NIBBLE_W]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // Next-state: accept in idle, one nibble per cycle in run, hold until drained in done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[cnt_q * NIBBLE_W +: NIBBLE_W] = slice_s;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          cout_d  = slice_cout;
`ifdef SEQ_ADDER_OVERFLOW_EN
          // Carry into the MSB differs from carry out of it.
          ovf_d   = slice_c3 ^ slice_cout;
`endif
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SEQ_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake and status outputs decode directly from the registered state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SEQ_ADDER_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_prefix_adder32.sv
// Self-checking bench for seq_prefix_adder32: directed cases, backpressure,
// mid-run reset and a randomized stream against an arithmetic reference model.
module tb_seq_prefix_adder32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;
`ifdef SEQ_ADDER_OVERFLOW_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  seq_prefix_adder32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SEQ_ADDER_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } res_t;

  // Reference: unsigned sum with carry, and signed overflow from integer range.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    res_t        r;
    logic [32:0] u;
    longint      sg;
    u   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    sg  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    r.s = u[31:0];
    r.c = u[32];
    r.v = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair and run until out_valid; reports latency and in_ready behaviour.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic ci,
                        output int lat, output bit ir_low);
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      step();
      w++;
    end
    if (!in_ready) chk("accept_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = ci;
    step();
    in_valid = 1'b0;
    lat      = 0;
    ir_low   = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_low = 1'b0;
      step();
      lat++;
    end
    if (in_ready) ir_low = 1'b0;
  endtask

  initial begin : stim
    int   lat;
    bit   ir_low;
    res_t r;
    int   pulses;
    res_t q[$];
    int   since;
    int   accepted;
    int   produced;
    bit   exp_ir;
    bit   exp_ov;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    // Reset state.
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
`ifdef SEQ_ADDER_OVERFLOW_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    step();

    // Wrap to zero with carry out; latency 8.
    out_ready = 1'b1;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, ir_low);
    chk("t1_latency", 64'(lat), 64'd8);
    chk("t1_in_ready_low", 64'(ir_low), 64'd1);
    chk("t1_sum", 64'(sum), 64'h0000_0000);
    chk("t1_cout", 64'(cout), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    step();
    chk("t1_drained", 64'(out_valid), 64'd0);

    // Mixed operands with carry-in.
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, lat, ir_low);
    chk("t2_latency", 64'(lat), 64'd8);
    chk("t2_sum", 64'(sum), 64'hACF1_3569);
    chk("t2_cout", 64'(cout), 64'd0);
`ifdef SEQ_ADDER_OVERFLOW_EN
    chk("t2_ovf", 64'(ovf), 64'd0);
`endif
    step();

    // Signed overflow at the positive boundary.
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, ir_low);
    chk("t3_sum", 64'(sum), 64'h8000_0000);
    chk("t3_cout", 64'(cout), 64'd0);
`ifdef SEQ_ADDER_OVERFLOW_EN
    chk("t3_ovf", 64'(ovf), 64'd1);
`endif
    step();

    // Backpressure: result held while out_ready is low, no accept in DONE.
    out_ready = 1'b0;
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, lat, ir_low);
    in_valid = 1'b1;
    a        = 32'h0000_0001;
    b        = 32'h0000_0002;
    cin      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(sum), 64'h8);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_handshake_in_ready", 64'(in_ready), 64'd1);
    chk("bp_handshake_out_valid", 64'(out_valid), 64'd0);
    step();
    chk("bp_new_accept_busy", 64'(busy), 64'd1);
    chk("bp_new_accept_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("bp_second_latency", 64'(lat), 64'd8);
    chk("bp_second_sum", 64'(sum), 64'h3);
    step();

    // Reset after nibble 3 is processed discards the transaction.
    in_valid = 1'b1;
    a        = $urandom;
    b        = $urandom;
    cin      = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_sum", 64'(sum), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) pulses++;
      step();
    end
    chk("mr_no_out_valid", 64'(pulses), 64'd0);

    // Randomized stream with random valid/ready; model predicts handshakes and results.
    since    = 0;
    accepted = 0;
    produced = 0;
    for (int cyc = 0; cyc < 40000 && produced < 1000; cyc++) begin
      in_valid  = (accepted < 1000) && ($urandom_range(0, 1) == 1);
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 1) == 1);
      exp_ir    = (q.size() == 0);
      exp_ov    = (q.size() != 0) && (since >= 8);
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_ir));
      chk("rnd_out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov && out_ready) begin
        r = q.pop_front();
        chk("rnd_sum", 64'(sum), 64'(r.s));
        chk("rnd_cout", 64'(cout), 64'(r.c));
`ifdef SEQ_ADDER_OVERFLOW_EN
        chk("rnd_ovf", 64'(ovf), 64'(r.v));
`endif
        produced++;
      end
      if (in_valid && exp_ir) begin
        q.push_back(model(a, b, cin));
        accepted++;
        since = -1;
      end
      step();
      since++;
    end
    chk("rnd_outputs", 64'(produced), 64'd1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_prefix_adder32.md
Name: seq_prefix_adder32

Overview:
- Multi-cycle 32-bit adder built around a 4-bit prefix-adder slice.
- Accepts one operand pair through a valid/ready handshake, then processes it one 4-bit nibble per cycle, LSB first, with a registered inter-nibble carry.
- Presents the sum and carry-out through a valid/ready output handshake.
- Trades latency for area in front of the datapath result bus.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of 4 and at least 4; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n: sampled on the clk rising edge, no asynchronous path.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nibble counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch a, b and cin into internal registers, clear the counter, load carry register=cin, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes nibble idx=counter: slice inputs are a_reg[4*idx+3:4*idx], b_reg[same range] and the carry register.
  - The slice's 4-bit sum is written to sum_reg[same range], and its carry-out is written to the carry register.
  - On the edge that processes nibble WIDTH/4-1: cout is loaded with the slice carry-out, out_valid is set, and the state goes to DONE.
- Latency: accept edge E0; nibbles are processed on E1..E(WIDTH/4); out_valid is high in the cycle after E(WIDTH/4). With the default, out_valid is high 8 cycles after the accept edge.
- DONE:
  - out_valid=1; sum and cout are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0 and the state goes to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept; the next accept is possible at the earliest one cycle after the output handshake.
- The sum output is driven from sum_reg. Partial nibbles are visible during RUN but are qualified only by out_valid.
- Inputs a, b and cin are don't-care outside the accept edge.
- Reset mid-operation (RUN or DONE): the transaction is discarded, no out_valid pulse follows, and in_ready=1 in the cycle after reset.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry out of the MSB.

Optional Feature:
- Macro: SEQ_ADDER_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit), meaning signed two's-complement overflow.
  - ovf is registered with cout on the final nibble edge: the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
  - The carry into bit WIDTH-1 is taken from the slice's internal bit-3 carry.
  - ovf has reset value 0 and is held in DONE like cout.
- When undefined: no ovf port and no associated logic; the block is otherwise identical.

Decomposition:
- Shared package seq_adder_pkg contains:
  - constant NIBBLE_W=4;
  - FSM state enum typedef (IDLE, RUN, DONE);
  - a function returning the nibble count for a given width.
- One sub-module, nibble_prefix_slice, which is purely combinational:
  - inputs: 4-bit x, 4-bit y, cin;
  - outputs: 4-bit s, cout, c3 (the carry into bit 3);
  - per-bit generate/propagate, two-level prefix carry tree, sum = propagate XOR carry.
- The top level holds the FSM, counter, operand/sum registers, carry register and handshakes.

Test Plan:
- a=0xFFFFFFFF, b=0x00000001, cin=0, out_ready=1 -> out_valid rises exactly 8 cycles after accept with sum=0x00000000, cout=1; in_ready=0 throughout.
- a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, cout=0; with SEQ_ADDER_OVERFLOW_EN, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0, SEQ_ADDER_OVERFLOW_EN defined -> sum=0x80000000, cout=0, ovf=1.
- Backpressure: after a=0x00000005, b=0x00000003, hold out_ready=0 for 5 cycles -> out_valid stays 1, sum stays 0x00000008, and in_ready stays 0 even with in_valid=1 held. Raise out_ready -> one handshake, then in_ready=1 the next cycle, and a new accept is taken.
- Reset mid-run: rst_n=0 for one edge after nibble 3 is processed -> in_ready=1, out_valid=0 and sum=0 in the next cycle; no out_valid appears for the discarded pair.
- Back-to-back random: 1000 random a, b, cin with random in_valid/out_ready -> each result matches a+b+cin. Exactly one output per accepted input, in order, and no accept outside IDLE.
